// File: rtl/ring_pkg.sv
// Shared definitions for the ring round-robin arbiter and the ring counter.
// Holds the arbiter state encoding plus the one-hot helpers both blocks use.
package ring_pkg;

   localparam int MAXW = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic int onehot_to_index(input logic [MAXW-1:0] v);
      int r;
      r = 0;
      for (int i = 0; i < MAXW; i++) begin
         if (v[i]) r = i;
      end
      return r;
   endfunction

   // Rotation is confined to the low w bits, so the top token wraps to bit 0.
   function automatic logic [MAXW-1:0] rotl1(input logic [MAXW-1:0] v, input int w);
      logic [MAXW-1:0] r;
      r = '0;
      for (int i = 0; i < MAXW; i++) begin
         if (i < w) begin
            if (i == w - 1) r[0] = v[i];
            else            r[i+1] = v[i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ring_rr_arbiter_if.sv
// Requester-side handshake bundle for ring_rr_arbiter.
// The master side is the requester group; the slave side is the arbiter.
interface ring_rr_arbiter_if #(
   parameter int WIDTH = 4
);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic             en;
   logic [WIDTH-1:0] req;
   logic             rel;
   logic [WIDTH-1:0] gnt;
   logic [IW-1:0]    gnt_id;
   logic             busy;
   logic             timeout;

   modport master (
      output en, req, rel,
      input  gnt, gnt_id, busy, timeout
   );

   modport slave (
      input  en, req, rel,
      output gnt, gnt_id, busy, timeout
   );

endinterface

// File: rtl/ring_rr_arbiter_rr_pick.sv
// Combinational circular priority select: first set req bit at or above
// the ptr token position, wrapping from the MSB back to bit 0.
module rr_pick
   import ring_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] req,
   input  logic [WIDTH-1:0] ptr,
   output logic [WIDTH-1:0] winner,
   output logic             any
);
   localparam int IW = $clog2(WIDTH);

   logic [IW-1:0] base;
   logic [IW:0]   sum;
   logic [IW-1:0] idx;
   logic          found;

   assign base = IW'(onehot_to_index(MAXW'(ptr)));
   assign any  = |req;

   // Offset k walks the ring starting at the token; the first hit wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int k = 0; k < WIDTH; k++) begin
         sum = {1'b0, base} + (IW+1)'(k);
         if (sum >= (IW+1)'(WIDTH)) sum = sum - (IW+1)'(WIDTH);
         idx = sum[IW-1:0];
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority token and an
// optional hold-time limit that reclaims a grant the holder never releases.
module ring_rr_arbiter
   import ring_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MAX_HOLD = 8
) (
   input logic               clk,
   input logic               rst,
   ring_rr_arbiter_if.slave  bus
);
   localparam int IW = $clog2(WIDTH);
   localparam int HW = (MAX_HOLD > 0) ? (($clog2(MAX_HOLD + 1) > 0) ? $clog2(MAX_HOLD + 1) : 1) : 1;

   state_t           state;
   logic [WIDTH-1:0] ptr;
   logic [HW-1:0]    hold_cnt;
   logic [WIDTH-1:0] gnt_q;
   logic [IW-1:0]    gnt_id_q;
   logic             busy_q;
   logic             timeout_q;

   logic [WIDTH-1:0] winner;
   logic             any;
   logic             held_req;
   logic             limit;

   rr_pick #(.WIDTH(WIDTH)) u_pick (
      .req    (bus.req),
      .ptr    (ptr),
      .winner (winner),
      .any    (any)
   );

   assign held_req = |(bus.req & gnt_q);
   assign limit    = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD - 1));

   assign bus.gnt     = gnt_q;
   assign bus.gnt_id  = gnt_id_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = timeout_q;

   // A release or a dropped request on the limit edge takes precedence,
   // so timeout only flags grants the hold limit actually reclaimed.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= WIDTH'(1);
         hold_cnt  <= '0;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.en && any) begin
                  gnt_q    <= winner;
                  gnt_id_q <= IW'(onehot_to_index(MAXW'(winner)));
                  busy_q   <= 1'b1;
                  hold_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (bus.rel || !held_req || limit) begin
                  gnt_q     <= '0;
                  gnt_id_q  <= '0;
                  busy_q    <= 1'b0;
                  state     <= IDLE;
                  ptr       <= WIDTH'(rotl1(MAXW'(gnt_q), WIDTH));
                  timeout_q <= limit && !bus.rel && held_req;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
